// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
//   Shared constants and helper functions for the calculator datapath blocks.
//   Used by bin_to_bcd_converter and bcd_digit_adj.
//
//   Contents:
//     ST_IDLE / ST_CONVERT / ST_DONE : converter FSM state encodings
//     BCD_BLANK       : digit code the 7-segment driver shows as blank
//     BCD_ADJ_THRESH  : double-dabble correction threshold (digit >= 5)
//     BCD_ADJ_ADD     : double-dabble correction amount (+3)
//     calc_clog2()    : ceil(log2(value)), minimum 1, for counter widths
//     digits_sufficient() : true when 10^num_digits > 2^data_width - 1
// ---------------------------------------------------------------------------
package calc_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [3:0] BCD_BLANK      = 4'hF;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  function automatic int calc_clog2(input int value);
    int width;
    width = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      width++;
    end
    return (width < 1) ? 1 : width;
  endfunction

  // Saturating integer comparison so that very wide configurations do not
  // wrap around and falsely pass the digit-count check.
  function automatic bit digits_sufficient(input int num_digits, input int data_width);
    longint unsigned max_val;
    longint unsigned pow10;
    max_val = (data_width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                 : ((64'd1 << data_width) - 64'd1);
    pow10 = 64'd1;
    for (int i = 0; i < num_digits; i++) begin
      if (pow10 > max_val) return 1'b1;
      if (pow10 > 64'hFFFF_FFFF_FFFF_FFFF / 64'd10) return 1'b1;
      pow10 = pow10 * 64'd10;
    end
    return pow10 > max_val;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
//   Combinational double-dabble correction for a single BCD digit: digits of
//   5 or more get 3 added so that the following left shift carries correctly
//   into the next decimal digit.
//
//   Ports:
//     digit_in   in  4  BCD digit before correction
//     digit_out  out 4  BCD digit after correction
// ---------------------------------------------------------------------------
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in + BCD_ADJ_ADD) : digit_in;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_converter
//   Sequential double-dabble converter sitting between calculator_core and
//   output_driver. Takes a DATA_WIDTH binary value (unsigned or two's
//   complement) and produces a sign-magnitude NUM_DIGITS-digit BCD result.
//   One conversion in flight; valid/ready handshake on both sides.
//
//   Parameters:
//     DATA_WIDTH  binary input width
//     NUM_DIGITS  BCD output digits, 10^NUM_DIGITS must exceed 2^DATA_WIDTH-1
//
//   Ports:
//     clk         in   1             clock, rising edge
//     rst         in   1             synchronous reset, active-high
//     i_data      in   DATA_WIDTH    binary value to convert
//     i_2s_comp   in   1             1: i_data is two's complement
//     i_valid     in   1             upstream data valid
//     o_ready     out  1             idle, can accept new data
//     o_bcd       out  4*NUM_DIGITS  BCD magnitude, digit 0 in [3:0]
//     o_negative  out  1             result is negative
//     o_valid     out  1             o_bcd / o_negative valid
//     i_ready     in   1             downstream accepts result
//
//   Build option:
//     LEADING_ZERO_BLANK_EN  when defined, leading zero digits above the most
//                            significant non-zero digit are replaced by
//                            BCD_BLANK; digit 0 is never blanked.
// ---------------------------------------------------------------------------
module bin_to_bcd_converter
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_2s_comp,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic                    o_negative,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int CNT_W = calc_clog2(DATA_WIDTH + 1);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(DATA_WIDTH - 1);

  // Reject configurations whose digit count cannot hold the largest input.
  if (!digits_sufficient(NUM_DIGITS, DATA_WIDTH)) begin : g_bad_digits
    $error("bin_to_bcd_converter: NUM_DIGITS too small for DATA_WIDTH");
  end

  logic [1:0]            state;
  logic [BCD_W-1:0]      bcd_acc;
  logic [DATA_WIDTH-1:0] mag_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  neg_reg;

  logic                  in_neg;
  logic [DATA_WIDTH-1:0] in_mag;
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W-1:0]      bcd_shifted;
  logic [BCD_W-1:0]      bcd_final;

  // Sign/magnitude split at accept time. The negation is done as an
  // unsigned DATA_WIDTH-bit operation: the most negative input maps to
  // exactly 2^(DATA_WIDTH-1), which still fits, so no extra bit is needed.
  assign in_neg = i_2s_comp & i_data[DATA_WIDTH-1];
  assign in_mag = in_neg ? (~i_data + DATA_WIDTH'(1)) : i_data;

  // One correction unit per digit; all digits are corrected in parallel
  // before the shift of this cycle.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (bcd_acc[4*g +: 4]),
      .digit_out (bcd_adj[4*g +: 4])
    );
  end

  // Corrected accumulator shifted left one place, pulling in the next
  // magnitude bit from the MSB end.
  assign bcd_shifted = {bcd_adj[BCD_W-2:0], mag_reg[DATA_WIDTH-1]};

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; everything above the first non-zero digit
  // becomes blank. Digit 0 is excluded so a zero result still shows "0".
  always_comb begin
    logic seen_nonzero;
    bcd_final    = bcd_shifted;
    seen_nonzero = 1'b0;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      if (bcd_shifted[4*d +: 4] != 4'd0) begin
        seen_nonzero = 1'b1;
      end
      if (!seen_nonzero) begin
        bcd_final[4*d +: 4] = BCD_BLANK;
      end
    end
  end
`else
  assign bcd_final = bcd_shifted;
`endif

  // Main FSM plus datapath. The final shift result is written straight into
  // the output registers on the DONE-entry edge, so blanking and output
  // capture add no cycles to the conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bcd_acc    <= '0;
      mag_reg    <= '0;
      bit_cnt    <= '0;
      neg_reg    <= 1'b0;
      o_bcd      <= '0;
      o_negative <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            neg_reg <= in_neg;
            mag_reg <= in_mag;
            bcd_acc <= '0;
            bit_cnt <= '0;
            state   <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          bcd_acc <= bcd_shifted;
          mag_reg <= {mag_reg[DATA_WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_SHIFT) begin
            o_bcd      <= bcd_final;
            o_negative <= neg_reg;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready = (state == ST_IDLE);
  assign o_valid = (state == ST_DONE);

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_converter
//   Scoreboard bench for bin_to_bcd_converter (DATA_WIDTH=16, NUM_DIGITS=5).
//   The driver pushes the expected decimal result of every accepted input;
//   a monitor compares it whenever the converter presents an output.
//   Honours LEADING_ZERO_BLANK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_converter;

  localparam int DW  = 16;
  localparam int ND  = 5;
  localparam int LAT = 16;

  typedef struct {
    logic [4*ND-1:0] bcd;
    logic            neg;
    int              accept_cyc;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [DW-1:0]   i_data;
  logic            i_2s_comp;
  logic            i_valid;
  logic            o_ready;
  logic [4*ND-1:0] o_bcd;
  logic            o_negative;
  logic            o_valid;
  logic            i_ready;

  int   checks;
  int   errors;
  int   cyc;
  bit   prev_valid;
  bit   bp_en;
  exp_t sb[$];

  bin_to_bcd_converter #(
    .DATA_WIDTH (DW),
    .NUM_DIGITS (ND)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_2s_comp  (i_2s_comp),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_bcd      (o_bcd),
    .o_negative (o_negative),
    .o_valid    (o_valid),
    .i_ready    (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain decimal arithmetic on the signed/unsigned value.
  function automatic exp_t ref_convert(input logic [DW-1:0] d, input logic tc);
    exp_t e;
    int   value;
    int   pow;
    bit   is_neg;
    bit   seen;
    is_neg = tc && d[DW-1];
    value  = is_neg ? (65536 - int'(d)) : int'(d);
    e.neg  = is_neg && (value != 0);
    e.bcd  = '0;
    e.accept_cyc = 0;
    pow = 1;
    for (int i = 0; i < ND; i++) begin
      e.bcd[4*i +: 4] = 4'((value / pow) % 10);
      pow = pow * 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    seen = 1'b0;
    for (int i = ND - 1; i >= 1; i--) begin
      if (e.bcd[4*i +: 4] != 4'd0) seen = 1'b1;
      if (!seen) e.bcd[4*i +: 4] = 4'hF;
    end
`else
    seen = 1'b0;
`endif
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic tc);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    i_data    = d;
    i_2s_comp = tc;
    i_valid   = 1'b1;
    while (!o_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got o_ready=0 expected 1 within 200 cycles");
      i_valid = 1'b0;
    end else begin
      e = ref_convert(d, tc);
      e.accept_cyc = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      i_valid   = 1'b0;
      i_data    = DW'($urandom);
      i_2s_comp = 1'($urandom);
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb.size() != 0 || o_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares every presented result against the scoreboard head and
  // retires the entry on the output handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (o_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got o_bcd=%0h expected no output", o_bcd);
        end else begin
          if (!prev_valid) begin
            checkOutput("latency", 32'(cyc - sb[0].accept_cyc), 32'(LAT));
          end
          checkOutput("o_bcd", 32'(o_bcd), 32'(sb[0].bcd));
          checkOutput("o_negative", 32'(o_negative), 32'(sb[0].neg));
          checkOutput("o_ready_in_done", 32'(o_ready), 32'd0);
          if (i_ready) void'(sb.pop_front());
        end
      end
      prev_valid = o_valid;
    end
  end

  // Random downstream backpressure, changed just after the edge so the
  // monitor sees a settled value.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    bp_en     = 1'b0;
    prev_valid = 1'b0;
    rst       = 1'b1;
    i_data    = '0;
    i_2s_comp = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_o_ready", 32'(o_ready), 32'd1);
    checkOutput("reset_o_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_o_bcd", 32'(o_bcd), 32'd0);
    checkOutput("reset_o_negative", 32'(o_negative), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner values.
    applyStimulus(16'd0, 1'b0);
    applyStimulus(16'hFFFF, 1'b0);
    applyStimulus(16'hFFFF, 1'b1);
    applyStimulus(16'h8000, 1'b1);
    applyStimulus(16'h7FFF, 1'b1);
    applyStimulus(16'h8000, 1'b0);
    applyStimulus(16'd42, 1'b0);
    applyStimulus(16'd0, 1'b1);
    waitDrain();

    // Held result under backpressure while a second request waits.
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    applyStimulus(16'd4321, 1'b0);
    fork
      applyStimulus(16'hFC18, 1'b1);
      begin
        n = 0;
        while (!o_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        checkOutput("bp_valid_seen", 32'(o_valid), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    waitDrain();

    // Reset in the middle of a conversion.
    applyStimulus(16'd999, 1'b0);
    waitDrain();
    applyStimulus(16'd5555, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    checkOutput("midreset_o_valid", 32'(o_valid), 32'd0);
    checkOutput("midreset_o_ready", 32'(o_ready), 32'd1);
    checkOutput("midreset_o_bcd", 32'(o_bcd), 32'd0);
    checkOutput("midreset_o_negative", 32'(o_negative), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'd1234, 1'b0);
    waitDrain();

    // Randomised traffic with random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(DW'($urandom), 1'($urandom));
    end
    waitDrain();
    bp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
